// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl
//   Sequencing controller between the keypad scanner and the lock actuator/display.
//   It turns the level-held key flags into single key events and buffers digits.
//   On '#' it checks the entry against the stored password and runs the
//   unlock / error / lockout timing. It also arbitrates the shared buzzer.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   key_value[3:0]        scanner code (0-9 digit, 11 '#', 12 '*')
//   key_number/star/sharp level flags, high while the key is held
//   buzz_key              scanner key-click request
//   buzz                  arbitrated buzzer drive
//   unlocked/locked_out/set_mode   state indications
//   digit_count[2:0]      digits held in the entry buffer
//   entry_digits[15:0]    entry buffer, newest digit in [3:0]
//   fail_count[1:0]       consecutive failed checks
module keypad_lock_ctrl #(
  parameter int unsigned CODE_LEN    = 4,
  parameter logic [15:0] RESET_CODE  = 16'h1234,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned OPEN_CYCLES = 32_750_000,
  parameter int unsigned ERR_CYCLES  = 16_375_000,
  parameter int unsigned LOCK_CYCLES = 327_500_000,
  parameter int unsigned BEEP_CYCLES = 3_275_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_value,
  input  logic        key_number,
  input  logic        key_star,
  input  logic        key_sharp,
  input  logic        buzz_key,
  output logic        buzz,
  output logic        unlocked,
  output logic        locked_out,
  output logic        set_mode,
  output logic [2:0]  digit_count,
  output logic [15:0] entry_digits,
  output logic [1:0]  fail_count
);

  localparam int unsigned DW      = 4 * CODE_LEN;
  localparam logic [2:0]  FULL    = 3'(CODE_LEN);
  localparam logic [1:0]  MF      = 2'(MAX_FAIL);
  localparam logic [31:0] T_OPEN  = 32'(OPEN_CYCLES);
  localparam logic [31:0] T_ERR   = 32'(ERR_CYCLES);
  localparam logic [31:0] T_LOCK  = 32'(LOCK_CYCLES);
  // OPEN chirp is on while the down-counter is still above this value
  localparam logic [31:0] BEEP_TH = 32'(OPEN_CYCLES - BEEP_CYCLES);

  typedef enum logic [2:0] {
    S_ENTRY, S_CHECK, S_OPEN, S_SET, S_ERR, S_LOCK
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] entry_q, entry_d;
  logic [15:0] pw_q, pw_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  fail_q, fail_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  flag_q, flag_qq;   // {sharp, star, number}
  logic        buzz_q, buzz_d;
  logic        unl_q, lck_q, set_q;

  // Edge detect: flag_q is the synchronised copy, flag_qq its previous value.
  // The event is processed one cycle after the flag rises.
  logic [2:0] rise;
  logic       ev_sharp, ev_star, ev_num, can_push;

  assign rise     = flag_q & ~flag_qq;
  assign ev_sharp = rise[2];
  assign ev_star  = rise[1] & ~rise[2];
  assign ev_num   = rise[0] & ~|rise[2:1] & (key_value <= 4'd9);
  assign can_push = ev_num & (cnt_q < FULL);

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    pw_d    = pw_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    unique case (state_q)
      S_ENTRY: begin
        if (ev_sharp) begin
          if (cnt_q == FULL) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_ERR;
            timer_d = T_ERR;
            entry_d = '0;
            cnt_d   = '0;
          end
        end else if (ev_star) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (can_push) begin
          entry_d = {entry_q[11:0], key_value};
          cnt_d   = cnt_q + 3'd1;
        end
      end
      S_CHECK: begin
        entry_d = '0;
        cnt_d   = '0;
        if (entry_q[DW-1:0] == pw_q[DW-1:0]) begin
          fail_d  = '0;
          timer_d = T_OPEN;
          state_d = S_OPEN;
        end else begin
          fail_d = fail_q + 2'd1;
          if (fail_d == MF) begin
            timer_d = T_LOCK;
            state_d = S_LOCK;
          end else begin
            timer_d = T_ERR;
            state_d = S_ERR;
          end
        end
      end
      S_OPEN: begin
        if (ev_sharp) begin
          state_d = S_ENTRY;
          timer_d = '0;
        end else if (ev_star) begin
          state_d = S_SET;
          timer_d = '0;
          entry_d = '0;
          cnt_d   = '0;
        end else if (timer_q <= 32'd1) begin
          state_d = S_ENTRY;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      S_SET: begin
        // buffer is cleared on both exits so ENTRY starts fresh
        if (ev_sharp) begin
          if (cnt_q == FULL) begin
            pw_d    = entry_q;
            entry_d = '0;
            cnt_d   = '0;
            state_d = S_ENTRY;
          end
        end else if (ev_star) begin
          entry_d = '0;
          cnt_d   = '0;
          state_d = S_ENTRY;
        end else if (can_push) begin
          entry_d = {entry_q[11:0], key_value};
          cnt_d   = cnt_q + 3'd1;
        end
      end
      S_ERR, S_LOCK: begin
        if (timer_q <= 32'd1) begin
          state_d = S_ENTRY;
          timer_d = '0;
          if (state_q == S_LOCK) fail_d = '0;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: state_d = S_ENTRY;
    endcase
  end

  // Outputs are registered from the next-state values so they line up
  // with the state they describe.
  always_comb begin
    buzz_d = buzz_key;
    unique case (state_d)
      S_ERR, S_LOCK: buzz_d = 1'b1;
      S_OPEN:        buzz_d = (timer_d > BEEP_TH) ? 1'b1 : buzz_key;
      default:       buzz_d = buzz_key;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ENTRY;
      entry_q <= '0;
      pw_q    <= RESET_CODE;
      cnt_q   <= '0;
      fail_q  <= '0;
      timer_q <= '0;
      flag_q  <= '0;
      flag_qq <= '0;
      buzz_q  <= 1'b0;
      unl_q   <= 1'b0;
      lck_q   <= 1'b0;
      set_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      pw_q    <= pw_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      flag_q  <= {key_sharp, key_star, key_number};
      flag_qq <= flag_q;
      buzz_q  <= buzz_d;
      unl_q   <= (state_d == S_OPEN);
      lck_q   <= (state_d == S_LOCK);
      set_q   <= (state_d == S_SET);
    end
  end

  assign buzz         = buzz_q;
  assign unlocked     = unl_q;
  assign locked_out   = lck_q;
  assign set_mode     = set_q;
  assign digit_count  = cnt_q;
  assign entry_digits = entry_q;
  assign fail_count   = fail_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Directed bench for keypad_lock_ctrl with shortened timers
// (OPEN=100, ERR=20, LOCK=200, BEEP=10).
module tb_keypad_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_value = 4'd15;
  logic        key_number = 1'b0, key_star = 1'b0, key_sharp = 1'b0;
  logic        buzz_key = 1'b0;
  logic        buzz, unlocked, locked_out, set_mode;
  logic [2:0]  digit_count;
  logic [15:0] entry_digits;
  logic [1:0]  fail_count;

  int n_chk = 0;
  int n_fail = 0;

  keypad_lock_ctrl #(
    .CODE_LEN(4), .RESET_CODE(16'h1234), .MAX_FAIL(3),
    .OPEN_CYCLES(100), .ERR_CYCLES(20), .LOCK_CYCLES(200), .BEEP_CYCLES(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_value(key_value),
    .key_number(key_number), .key_star(key_star), .key_sharp(key_sharp),
    .buzz_key(buzz_key), .buzz(buzz), .unlocked(unlocked),
    .locked_out(locked_out), .set_mode(set_mode), .digit_count(digit_count),
    .entry_digits(entry_digits), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  // run-length monitors: length of the most recent completed high pulse
  int unl_run = 0, unl_len = 0, buz_run = 0, buz_len = 0, lck_run = 0, lck_len = 0;
  always @(negedge clk) begin
    if (unlocked) unl_run++;
    else begin if (unl_run != 0) unl_len = unl_run; unl_run = 0; end
    if (buzz) buz_run++;
    else begin if (buz_run != 0) buz_len = buz_run; buz_run = 0; end
    if (locked_out) lck_run++;
    else begin if (lck_run != 0) lck_len = lck_run; lck_run = 0; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind: 0 digit, 1 star, 2 sharp. Returns 4 negedges after the flag rose.
  task automatic press(input int kind, input logic [3:0] v);
    @(negedge clk);
    key_value = v;
    case (kind)
      0: key_number = 1'b1;
      1: key_star   = 1'b1;
      default: key_sharp = 1'b1;
    endcase
    repeat (2) @(negedge clk);
    key_number = 1'b0; key_star = 1'b0; key_sharp = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press(0, code[4*i +: 4]);
    press(2, 4'd11);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] outs();
    return {7'd0, buzz, unlocked, locked_out, set_mode, digit_count, entry_digits, fail_count};
  endfunction

  initial begin
    // reset state
    wait_cyc(3);
    check("reset_outs", outs(), 32'd0);
    rst_n = 1'b1;
    wait_cyc(2);

    // correct code, with digit and unlock latency measured by hand
    @(negedge clk); key_value = 4'd1; key_number = 1'b1;
    @(negedge clk); check("dig_lat_n1", 32'(digit_count), 32'd0);
    @(negedge clk); check("dig_lat_n2", 32'(digit_count), 32'd1);
    key_number = 1'b0;
    wait_cyc(2);
    press(0, 4'd2); press(0, 4'd3); press(0, 4'd4);
    check("entry_1234", 32'(entry_digits), 32'h1234);
    check("count_4", 32'(digit_count), 32'd4);
    @(negedge clk); key_sharp = 1'b1;
    @(negedge clk);
    @(negedge clk); check("unl_n2", 32'(unlocked), 32'd0);
    @(negedge clk); check("unl_n3", 32'(unlocked), 32'd1);
    check("beep_start", 32'(buzz), 32'd1);
    check("open_clear", 32'(digit_count), 32'd0);
    key_sharp = 1'b0;
    wait_cyc(150);
    check("open_len", 32'(unl_len), 32'd100);
    check("beep_len", 32'(buz_len), 32'd10);
    check("open_fail0", 32'(fail_count), 32'd0);

    // three wrong codes: ERR, ERR, LOCKOUT
    enter_code(16'h1235);
    check("err1_fail", 32'(fail_count), 32'd1);
    check("err1_buzz", 32'(buzz), 32'd1);
    wait_cyc(40);
    check("err1_len", 32'(buz_len), 32'd20);
    enter_code(16'h1235);
    check("err2_fail", 32'(fail_count), 32'd2);
    wait_cyc(40);
    enter_code(16'h1235);
    check("lock_on", 32'(locked_out), 32'd1);
    check("lock_fail", 32'(fail_count), 32'd3);
    enter_code(16'h1234);
    check("lock_ign_cnt", 32'(digit_count), 32'd0);
    check("lock_ign_unl", 32'(unlocked), 32'd0);
    check("lock_still", 32'(locked_out), 32'd1);
    wait_cyc(220);
    check("lock_len", 32'(lck_len), 32'd200);
    check("lock_exit_fail", 32'(fail_count), 32'd0);

    // clear, unlock, then digit saturation
    press(0, 4'd1); press(0, 4'd2); press(1, 4'd12);
    check("star_clear", {16'd0, entry_digits}, 32'd0);
    check("star_cnt", 32'(digit_count), 32'd0);
    enter_code(16'h1234);
    check("unl_after_clr", 32'(unlocked), 32'd1);
    wait_cyc(120);
    for (int d = 1; d <= 5; d++) press(0, 4'(d));
    check("sat_cnt", 32'(digit_count), 32'd4);
    check("sat_entry", 32'(entry_digits), 32'h1234);
    press(1, 4'd12);

    // change password to 9876
    enter_code(16'h1234);
    press(1, 4'd12);
    check("set_on", 32'(set_mode), 32'd1);
    check("set_unl", 32'(unlocked), 32'd0);
    for (int i = 3; i >= 0; i--) press(0, 4'(9 - (3 - i)));
    check("set_entry", 32'(entry_digits), 32'h9876);
    press(2, 4'd11);
    check("set_off", 32'(set_mode), 32'd0);
    enter_code(16'h1234);
    check("old_pw_err", 32'(fail_count), 32'd1);
    check("old_pw_unl", 32'(unlocked), 32'd0);
    wait_cyc(30);
    enter_code(16'h9876);
    check("new_pw_unl", 32'(unlocked), 32'd1);
    check("new_pw_fail", 32'(fail_count), 32'd0);
    press(2, 4'd11);
    check("relock", 32'(unlocked), 32'd0);

    // long hold stores one digit; invalid code stores nothing
    @(negedge clk); key_value = 4'd5; key_number = 1'b1;
    wait_cyc(1000);
    key_number = 1'b0;
    wait_cyc(2);
    check("hold_cnt", 32'(digit_count), 32'd1);
    check("hold_entry", 32'(entry_digits), 32'h0005);
    press(1, 4'd12);
    press(0, 4'd15);
    check("bad_digit", 32'(digit_count), 32'd0);
    buzz_key = 1'b1;
    wait_cyc(2);
    check("click_pass", 32'(buzz), 32'd1);
    buzz_key = 1'b0;
    wait_cyc(2);
    check("click_off", 32'(buzz), 32'd0);

    // reset during LOCKOUT
    for (int k = 0; k < 3; k++) begin enter_code(16'h4321); wait_cyc(25); end
    check("lock2_on", 32'(locked_out), 32'd1);
    @(negedge clk); rst_n = 1'b0;
    #1 check("rst_lock_outs", outs(), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    wait_cyc(2);

    // set password 5555, then reset mid SET; 1234 must work again
    enter_code(16'h1234);
    press(1, 4'd12);
    for (int i = 0; i < 4; i++) press(0, 4'd5);
    press(2, 4'd11);
    enter_code(16'h5555);
    check("pw5555_unl", 32'(unlocked), 32'd1);
    press(1, 4'd12);
    press(0, 4'd7);
    check("set2_on", 32'(set_mode), 32'd1);
    @(negedge clk); rst_n = 1'b0;
    #1 check("rst_set_outs", outs(), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    wait_cyc(2);
    enter_code(16'h1234);
    check("rst_pw_unl", 32'(unlocked), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
